// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle fetch/execute sequencer for the 9-bit-instruction
// processor. Owns the program counter and instruction register, runs the
// req/done handshake, gates decoder write enables to a single commit cycle,
// stalls loads for MEM_LAT cycles and resolves jumps through the jump LUT.
module exec_sequencer #(
  parameter int          PC_W    = 10,
  parameter int          MEM_LAT = 1,
  parameter logic [3:0]  HALT_OP = 4'b1111
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic [8:0]      mach_code,
  input  logic            flag_in,
  input  logic [PC_W-1:0] jmp_target,
  output logic [PC_W-1:0] prog_ctr,
  output logic [8:0]      ir,
  output logic [2:0]      jptr,
  output logic            rf_we_gate,
  output logic            dm_we_gate,
  output logic            dm_re,
  output logic            busy,
  output logic            done,
  output logic [15:0]     instr_cnt
);

  localparam logic [3:0] OP_LD = 4'b1001;
  localparam logic [3:0] OP_ST = 4'b1010;
  localparam logic [3:0] OP_J  = 4'b1011;
  localparam logic [2:0] LAT   = 3'(MEM_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_DONE
  } state_t;

  state_t          state;
  logic [2:0]      mem_cnt;
  logic [3:0]      op;
  logic [3:0]      fetch_op;
  logic            jump_taken;
  logic [PC_W-1:0] pc_inc;
  logic [15:0]     cnt_inc;

  // Decode helpers: op of the held instruction, op of the one being fetched.
  assign op         = ir[3:0];
  assign fetch_op   = mach_code[3:0];
  assign jptr       = ir[6:4];
  assign jump_taken = (op == OP_J) && (!ir[8] || flag_in);
  assign pc_inc     = prog_ctr + PC_W'(1);
  assign cnt_inc    = (instr_cnt == 16'hFFFF) ? instr_cnt : instr_cnt + 16'd1;

  // Sequencer FSM with registered outputs; gates for the EXEC cycle are
  // decoded from mach_code while leaving FETCH so they line up with ir.
  always_ff @(posedge clk) begin
    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // mixing in blocking assignments would create ordering-dependent races.
    if (reset) begin
      state      <= S_IDLE;
      prog_ctr   <= '0;
      ir         <= '0;
      mem_cnt    <= '0;
      instr_cnt  <= '0;
      rf_we_gate <= 1'b0;
      dm_we_gate <= 1'b0;
      dm_re      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            state     <= S_FETCH;
            prog_ctr  <= '0;
            instr_cnt <= '0;
            busy      <= 1'b1;
          end
        end

        S_FETCH: begin
          ir    <= mach_code;
          state <= S_EXEC;
          if (fetch_op == HALT_OP) begin
            rf_we_gate <= 1'b0;
            dm_we_gate <= 1'b0;
            dm_re      <= 1'b0;
          end else begin
            rf_we_gate <= !(fetch_op == OP_LD || fetch_op == OP_ST || fetch_op == OP_J);
            dm_we_gate <= (fetch_op == OP_ST);
            dm_re      <= (fetch_op == OP_LD);
          end
        end

        S_EXEC: begin
          rf_we_gate <= 1'b0;
          dm_we_gate <= 1'b0;
          dm_re      <= 1'b0;
          if (op == HALT_OP) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (op == OP_LD) begin
            // Read strobe stays up through MEM; the write commits on the last cycle.
            state      <= S_MEM;
            dm_re      <= 1'b1;
            mem_cnt    <= LAT;
            rf_we_gate <= (LAT == 3'd1);
          end else begin
            prog_ctr  <= jump_taken ? jmp_target : pc_inc;
            instr_cnt <= cnt_inc;
            state     <= S_FETCH;
          end
        end

        S_MEM: begin
          if (mem_cnt == 3'd1) begin
            rf_we_gate <= 1'b0;
            dm_re      <= 1'b0;
            mem_cnt    <= '0;
            prog_ctr   <= pc_inc;
            instr_cnt  <= cnt_inc;
            state      <= S_FETCH;
          end else begin
            mem_cnt    <= mem_cnt - 3'd1;
            rf_we_gate <= (mem_cnt == 3'd2);
          end
        end

        S_DONE: begin
          if (!req) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle fetch/execute sequencer for the 9-bit-instruction processor.
- Owns the program counter and the instruction register, and runs the start/done handshake with the testbench or host.
- Gates the register-file and data-memory write enables produced by the instruction decoder, so each write commits in exactly one cycle.
- Inserts wait cycles for loads, resolves jumps via the jump-target LUT, and stops on HALT.

Parameters:
- PC_W, 10, program counter width; the PC wraps modulo 2^PC_W.
- MEM_LAT, 1, data-memory read latency in cycles for LD; legal range 1..7.
- HALT_OP, 4'b1111, opcode that ends the program.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  start request; level-sensitive.
- mach_code  in  9  instruction ROM output at prog_ctr; combinational ROM.
- flag_in  in  1  ALU condition flag; sampled in EXEC.
- jmp_target  in  PC_W  jump LUT output for index jptr.
- prog_ctr  out  PC_W  instruction ROM address.
- ir  out  9  registered instruction; drives the decoder.
- jptr  out  3  jump LUT index, equal to ir[6:4].
- rf_we_gate  out  1  register-file write qualifier; ANDed with the decoder's WenR.
- dm_we_gate  out  1  data-memory write qualifier; ANDed with the decoder's WenD.
- dm_re  out  1  data-memory read strobe.
- busy  out  1  high in FETCH, EXEC and MEM.
- done  out  1  high in DONE.
- instr_cnt  out  16  retired-instruction count, saturating.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: state=IDLE, prog_ctr=0, ir=0, instr_cnt=0, MEM counter=0, all other outputs 0.
- Reset mid-operation: next edge forces IDLE with the reset values above. No write gate may be asserted in the reset cycle.
- Opcode decode: op = ir[3:0]. LD=4'b1001, ST=4'b1010, J=4'b1011, HALT=HALT_OP.
- Jump condition: ir[8]=0 means unconditional; ir[8]=1 means taken only if flag_in=1.
- IDLE: outputs idle. If req=1, go to FETCH, clear prog_ctr to 0 and clear instr_cnt.
- FETCH (1 cycle): ir <= mach_code, then go to EXEC. Write gates are 0.
- EXEC (1 cycle), by opcode:
  - ALU ops: rf_we_gate=1.
  - ST: dm_we_gate=1.
  - LD: dm_re=1, load counter with MEM_LAT, go to MEM.
  - HALT: no gates, go to DONE; prog_ctr holds.
  - J taken: prog_ctr <= jmp_target.
  - Non-LD, non-HALT ops: prog_ctr <= prog_ctr+1 unless the jump is taken. instr_cnt increments. Go to FETCH.
  - Untaken J: PC+1 with no gates.
- MEM: dm_re held at 1 and the counter decrements each cycle. On the cycle the counter reaches 1: rf_we_gate=1, prog_ctr+1, instr_cnt increments, go to FETCH. Total LD latency is 2+MEM_LAT cycles.
- DONE: done=1, busy=0. Stay while req=1; go to IDLE when req=0, which drops done the cycle after req falls. A new program needs req low then high.
- req low during busy: ignored; the program runs to HALT.
- PC wrap: all-ones +1 gives 0, with no error.
- instr_cnt: saturates at 16'hFFFF. HALT is not counted.
- Exclusivity: rf_we_gate and dm_we_gate are never both 1. Each is high for at most one cycle per instruction.
- Instruction timing: ALU, ST and J take 2 cycles each.

Test Plan:
- Reset then req=1: ROM 0:ADD, 1:ADD, 2:HALT → prog_ctr sequence 0,0,1,1,2,2. rf_we_gate pulses at cycles 2 and 4; done=1 at cycle 6; instr_cnt=2.
- MEM_LAT=3, ROM 0:LD, 1:HALT → dm_re high 4 cycles; a single rf_we_gate on the final MEM cycle; prog_ctr=1 after 5 cycles.
- Conditional jump: ir=9'b1_0010_1011 (jptr=2), jmp_target=10'h040.
  - flag_in=1 → prog_ctr=0x040, no gates.
  - Repeat with flag_in=0 → prog_ctr=PC+1.
- ST at PC 5 → dm_we_gate single pulse, rf_we_gate stays 0, prog_ctr=6.
- Reset asserted during MEM → next cycle state IDLE, prog_ctr=0, no rf_we_gate pulse, done=0.
- Jump to 10'h3FF where the instruction is ADD → next prog_ctr=0 (wrap). Holding req=1 after HALT keeps done=1; req=0 → done=0 the next cycle.
